// File: rtl/enc_8to3_queue.sv
`default_nettype none
// ============================================================================
// Module      : enc_8to3_queue
// Description : Sequential 8-to-3 priority encoder. Multi-hot requests are
//               collected into a pending set and drained one 3-bit index at
//               a time over a valid/ready handshake, clearing each bit as it
//               is granted.
//               Optional macro ENC_RR_EN: round-robin selection from the
//               last granted index instead of fixed priority.
// Revision    : 1.0 - initial release
// ============================================================================
module enc_8to3_queue #(
  parameter bit PRIO_HIGH = 1'b1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic [7:0] req_in,
  input  logic       req_vld,
  output logic [2:0] out_idx,
  output logic       out_vld,
  input  logic       out_rdy,
  output logic [7:0] pend,
  output logic       busy,
  output logic       dup
);

  logic [7:0] r_pend;
  logic [2:0] r_out_idx;
  logic       r_out_vld;
  logic       r_dup;

  logic [2:0] w_sel_idx;
  logic       w_load;
  logic [7:0] w_gnt_oh;
  logic [7:0] w_req_masked;
  logic [7:0] w_pend_next;
  logic       w_dup_next;

  // A new grant can enter the output register when it is empty or draining.
  assign w_load = (!r_out_vld || out_rdy) && (r_pend != 8'd0);

`ifdef ENC_RR_EN
  // Pointer starts just "behind" the fixed-priority winner so the first grant matches it.
  localparam logic [2:0] C_LAST_RST = PRIO_HIGH ? 3'd0 : 3'd7;

  logic [2:0] r_last_idx;

  // Track the most recently loaded index as the round-robin origin.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last_idx <= C_LAST_RST;
    end else if (w_load) begin
      r_last_idx <= w_sel_idx;
    end
  end

  // Walk away from the last grant, wrapping, and take the first pending bit; offset 8 revisits last_idx itself.
  always_comb begin
    logic       found;
    logic [2:0] cand;
    w_sel_idx = 3'd0;
    found     = 1'b0;
    cand      = 3'd0;
    for (int k = 1; k <= 8; k++) begin
      cand = PRIO_HIGH ? (r_last_idx - 3'(k)) : (r_last_idx + 3'(k));
      if (!found && r_pend[cand]) begin
        w_sel_idx = cand;
        found     = 1'b1;
      end
    end
  end
`else
  // Fixed priority: scan from the winning end of the vector and take the first pending bit.
  always_comb begin
    logic       found;
    logic [2:0] cand;
    w_sel_idx = 3'd0;
    found     = 1'b0;
    cand      = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = PRIO_HIGH ? 3'(7 - i) : 3'(i);
      if (!found && r_pend[cand]) begin
        w_sel_idx = cand;
        found     = 1'b1;
      end
    end
  end
`endif

  // Next pending set and duplicate detection; a re-request of the bit being granted survives.
  always_comb begin
    w_gnt_oh     = w_load ? (8'd1 << w_sel_idx) : 8'd0;
    w_req_masked = req_vld ? req_in : 8'd0;
    w_pend_next  = (r_pend & ~w_gnt_oh) | w_req_masked;
    w_dup_next   = |(w_req_masked & r_pend & ~w_gnt_oh);
  end

  // Pending set, output register and duplicate pulse.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pend    <= 8'd0;
      r_out_idx <= 3'd0;
      r_out_vld <= 1'b0;
      r_dup     <= 1'b0;
    end else begin
      r_pend <= w_pend_next;
      r_dup  <= w_dup_next;
      if (w_load) begin
        r_out_idx <= w_sel_idx;
        r_out_vld <= 1'b1;
      end else if (r_out_vld && out_rdy) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign out_idx = r_out_idx;
  assign out_vld = r_out_vld;
  assign pend    = r_pend;
  assign dup     = r_dup;
  assign busy    = (r_pend != 8'd0) || r_out_vld;

endmodule
`default_nettype wire

// File: tb/tb_enc_8to3_queue.sv
`default_nettype none
// ============================================================================
// Module      : tb_enc_8to3_queue
// Description : Self-checking bench for enc_8to3_queue (PRIO_HIGH=1), with a
//               behavioural model of the pending set and output register.
//               Follows ENC_RR_EN when the macro is defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_enc_8to3_queue;

  localparam bit C_PRIO_HIGH = 1'b1;

  logic       clk     = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] req_in  = 8'd0;
  logic       req_vld = 1'b0;
  logic       out_rdy = 1'b0;
  logic [2:0] out_idx;
  logic       out_vld;
  logic [7:0] pend;
  logic       busy;
  logic       dup;

  int n_cmp = 0;
  int n_bad = 0;

  // Behavioural model state
  logic [7:0] m_pend;
  logic [2:0] m_idx;
  logic [2:0] m_last;
  logic       m_vld;
  logic       m_dup;

  enc_8to3_queue #(.PRIO_HIGH(C_PRIO_HIGH)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .req_in  (req_in),
    .req_vld (req_vld),
    .out_idx (out_idx),
    .out_vld (out_vld),
    .out_rdy (out_rdy),
    .pend    (pend),
    .busy    (busy),
    .dup     (dup)
  );

  always #5 clk = ~clk;

  // Winner among pending bits; returns -1 when nothing is pending.
  function automatic int pick(input logic [7:0] p, input int last);
    int idx;
`ifdef ENC_RR_EN
    for (int s = 1; s <= 8; s++) begin
      idx = C_PRIO_HIGH ? ((last - s + 16) % 8) : ((last + s) % 8);
      if (p[idx]) return idx;
    end
`else
    for (int s = 0; s < 8; s++) begin
      idx = C_PRIO_HIGH ? (7 - s) : s;
      if (p[idx]) return idx;
    end
`endif
    return -1;
  endfunction

  task automatic model_reset();
    m_pend = 8'd0;
    m_idx  = 3'd0;
    m_vld  = 1'b0;
    m_dup  = 1'b0;
    m_last = C_PRIO_HIGH ? 3'd0 : 3'd7;
  endtask

  // Advance the model by one clock using the inputs currently driven.
  task automatic model_step();
    logic [7:0] gnt;
    logic [7:0] req;
    int w;
    gnt = 8'd0;
    req = req_vld ? req_in : 8'd0;
    w   = -1;
    if ((!m_vld || out_rdy) && m_pend != 8'd0) begin
      w   = pick(m_pend, int'(m_last));
      gnt = 8'd1 << w;
    end
    m_dup  = (req & m_pend & ~gnt) != 8'd0;
    m_pend = (m_pend & ~gnt) | req;
    if (w >= 0) begin
      m_idx  = 3'(w);
      m_last = 3'(w);
      m_vld  = 1'b1;
    end else if (m_vld && out_rdy) begin
      m_vld = 1'b0;
    end
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".pend"},    pend,           m_pend);
    check({tag, ".out_vld"}, {7'd0, out_vld}, {7'd0, m_vld});
    check({tag, ".out_idx"}, {5'd0, out_idx}, {5'd0, m_idx});
    check({tag, ".dup"},     {7'd0, dup},     {7'd0, m_dup});
    check({tag, ".busy"},    {7'd0, busy},    {7'd0, (m_pend != 8'd0) || m_vld});
  endtask

  // Drive one cycle of inputs, step the model, then sample just after the edge.
  task automatic cyc(input string tag, input logic v, input logic [7:0] r, input logic rdy);
    req_vld = v;
    req_in  = r;
    out_rdy = rdy;
    model_step();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  initial begin
    logic [2:0] seq [4];
    logic [2:0] exp_seq [4];

    // Reset state
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    reset_n = 1'b1;

    // Reset/basic: single request, two-edge latency
    cyc("basic_req", 1'b1, 8'b0000_0100, 1'b1);
    check("basic_vld_lat1", {7'd0, out_vld}, 8'd0);
    cyc("basic_gnt", 1'b0, 8'd0, 1'b1);
`ifndef ENC_RR_EN
    check("basic_idx", {5'd0, out_idx}, 8'd2);
`endif
    check("basic_vld", {7'd0, out_vld}, 8'd1);
    cyc("basic_done", 1'b0, 8'd0, 1'b1);
    check("basic_busy", {7'd0, busy}, 8'd0);

    // Multi-hot drain
    cyc("multi_req", 1'b1, 8'b1010_0010, 1'b1);
    cyc("multi_g0", 1'b0, 8'd0, 1'b1);
`ifndef ENC_RR_EN
    check("multi_idx0", {5'd0, out_idx}, 8'd7);
`endif
    cyc("multi_g1", 1'b0, 8'd0, 1'b1);
    cyc("multi_g2", 1'b0, 8'd0, 1'b1);
`ifndef ENC_RR_EN
    check("multi_idx2", {5'd0, out_idx}, 8'd1);
`endif
    cyc("multi_done", 1'b0, 8'd0, 1'b1);

    // Backpressure: output holds while not ready
    cyc("bp_req", 1'b1, 8'b0001_1000, 1'b0);
    for (int i = 0; i < 4; i++) cyc("bp_hold", 1'b0, 8'd0, 1'b0);
`ifndef ENC_RR_EN
    check("bp_idx", {5'd0, out_idx}, 8'd4);
    check("bp_pend", pend, 8'b0000_1000);
`endif
    cyc("bp_release", 1'b0, 8'd0, 1'b1);
    cyc("bp_drain", 1'b0, 8'd0, 1'b1);

    // Same-cycle set/clear, then a true duplicate
    cyc("sc_req", 1'b1, 8'b0100_0000, 1'b1);
    cyc("sc_load", 1'b1, 8'b0100_0000, 1'b1);
    check("sc_pend6", {7'd0, pend[6]}, 8'd1);
    check("sc_dup", {7'd0, dup}, 8'd0);
    check("sc_idx", {5'd0, out_idx}, 8'd6);
    cyc("sc_load2", 1'b0, 8'd0, 1'b1);
    check("sc_idx2", {5'd0, out_idx}, 8'd6);
    cyc("dup_set", 1'b1, 8'b0100_0000, 1'b0);
    cyc("dup_hit", 1'b1, 8'b0100_0000, 1'b0);
    check("dup_pulse", {7'd0, dup}, 8'd1);
    cyc("dup_clear", 1'b0, 8'd0, 1'b0);
    check("dup_gone", {7'd0, dup}, 8'd0);
    cyc("dup_drain0", 1'b0, 8'd0, 1'b1);
    cyc("dup_drain1", 1'b0, 8'd0, 1'b1);

    // Reset mid-operation: asynchronous clear, no grant after release
    cyc("mid_fill", 1'b1, 8'hFF, 1'b0);
    cyc("mid_load", 1'b0, 8'd0, 1'b0);
    cyc("mid_full", 1'b1, 8'hFF, 1'b0);
    req_vld = 1'b0;
    req_in  = 8'd0;
    #3;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("mid_async");
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    cyc("mid_after", 1'b0, 8'd0, 1'b1);

    // Round-robin vs fixed priority under sustained two-bit requests
    cyc("rr_req", 1'b1, 8'b1000_0001, 1'b1);
    for (int i = 0; i < 4; i++) begin
      cyc("rr_step", 1'b1, 8'b1000_0001, 1'b1);
      seq[i] = out_idx;
    end
`ifdef ENC_RR_EN
    exp_seq = '{3'd7, 3'd0, 3'd7, 3'd0};
`else
    exp_seq = '{3'd7, 3'd7, 3'd7, 3'd7};
`endif
    for (int i = 0; i < 4; i++) check("rr_seq", {5'd0, seq[i]}, {5'd0, exp_seq[i]});
    for (int i = 0; i < 4; i++) cyc("rr_drain", 1'b0, 8'd0, 1'b1);

    // Randomised traffic
    for (int i = 0; i < 400; i++) begin
      logic       v;
      logic [7:0] r;
      logic       rdy;
      v   = ($urandom_range(0, 2) != 0);
      r   = ($urandom_range(0, 3) == 0) ? 8'd0 : 8'($urandom);
      rdy = ($urandom_range(0, 3) != 0);
      cyc("rand", v, r, rdy);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
